// File: rtl/btb_predictor.sv
// Branch target buffer with 2-bit saturating direction counters.
// Same-cycle fetch lookup; resolved-branch updates go through a one-entry write buffer.
module btb_predictor #(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned IDX_W   = 6,
  parameter int unsigned TAG_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        inval,
  input  logic [31:0] pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        update,
  input  logic [31:0] update_pc,
  input  logic        act_taken,
  input  logic [31:0] act_target
);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       ctr;
  } entry_t;

  entry_t             tbl_q [ENTRIES];
  entry_t             pend_q, pend_d;
  logic [IDX_W-1:0]   pend_idx_q;
  logic               pend_valid_q, pend_valid_d;

  logic [IDX_W-1:0]   lk_idx, up_idx;
  logic [TAG_W-1:0]   lk_tag, up_tag;
  entry_t             lk_e, up_e;
  logic               lk_hit, up_hit, upd_en;
  logic               unused_pc_bits;

  assign lk_idx = pc[IDX_W+1:2];
  assign lk_tag = pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_idx = update_pc[IDX_W+1:2];
  assign up_tag = update_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign unused_pc_bits = ^{pc[31:IDX_W+TAG_W+2], pc[1:0],
                            update_pc[31:IDX_W+TAG_W+2], update_pc[1:0]};

  // Both lookup and update see the pending entry in place of the array entry.
  always_comb begin
    lk_e        = (pend_valid_q && (pend_idx_q == lk_idx)) ? pend_q : tbl_q[lk_idx];
    lk_hit      = lk_e.valid && (lk_e.tag == lk_tag);
    pred_taken  = lk_hit && lk_e.ctr[1];
    pred_target = lk_hit ? lk_e.target : '0;
  end

  always_comb begin
    up_e         = (pend_valid_q && (pend_idx_q == up_idx)) ? pend_q : tbl_q[up_idx];
    up_hit       = up_e.valid && (up_e.tag == up_tag);
    upd_en       = update && !stall && !inval;
    pend_d       = up_e;
    pend_valid_d = 1'b0;
    if (upd_en && up_hit) begin
      pend_valid_d = 1'b1;
      if (act_taken) begin
        pend_d.target = act_target;
        if (up_e.ctr != 2'b11) pend_d.ctr = up_e.ctr + 2'b01;
      end else if (up_e.ctr != 2'b00) begin
        pend_d.ctr = up_e.ctr - 2'b01;
      end
    end else if (upd_en && act_taken) begin
      pend_valid_d  = 1'b1;
      pend_d.valid  = 1'b1;
      pend_d.tag    = up_tag;
      pend_d.target = act_target;
      pend_d.ctr    = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) tbl_q[i] <= '0;
      pend_q       <= '0;
      pend_idx_q   <= '0;
      pend_valid_q <= 1'b0;
    end else if (inval) begin
      for (int unsigned i = 0; i < ENTRIES; i++) tbl_q[i].valid <= 1'b0;
      pend_valid_q <= 1'b0;
    end else begin
      if (pend_valid_q) tbl_q[pend_idx_q] <= pend_q;
      pend_valid_q <= pend_valid_d;
      if (pend_valid_d) begin
        pend_q     <= pend_d;
        pend_idx_q <= up_idx;
      end
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed, table-driven bench for btb_predictor: one vector per clock cycle,
// outputs compared against hand-computed lookup results before each edge.
module tb_btb_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, inval, update, act_taken;
  logic [31:0] pc, update_pc, act_target;
  logic        pred_taken;
  logic [31:0] pred_target;

  btb_predictor #(.ENTRIES(64), .IDX_W(6), .TAG_W(8)) dut (
    .clk(clk), .rst(rst), .stall(stall), .inval(inval), .pc(pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .update(update), .update_pc(update_pc), .act_taken(act_taken),
    .act_target(act_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        upd;
    logic [31:0] upc;
    logic        at;
    logic [31:0] atg;
    logic        stl;
    logic        inv;
    logic [31:0] lpc;
    logic        exp_taken;
    logic [31:0] exp_target;
  } vec_t;

  localparam logic [31:0] PA = 32'h8000_0100;  // idx 0, tag 01
  localparam logic [31:0] PB = 32'h8000_4100;  // idx 0, tag 41
  localparam logic [31:0] PC = 32'h8000_0104;  // idx 1, tag 01
  localparam logic [31:0] TA = 32'h8000_0200;
  localparam logic [31:0] TB = 32'h8000_0300;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic upd, input logic [31:0] upc, input logic at,
                              input logic [31:0] atg, input logic stl, input logic inv,
                              input logic [31:0] lpc, input logic et, input logic [31:0] etg);
    vec_t v;
    v.upd = upd; v.upc = upc; v.at = at; v.atg = atg; v.stl = stl; v.inv = inv;
    v.lpc = lpc; v.exp_taken = et; v.exp_target = etg;
    return v;
  endfunction

  task automatic check(input string name, input logic et, input logic [31:0] etg);
    n_vec++;
    if (pred_taken !== et || pred_target !== etg) begin
      n_bad++;
      $display("FAIL %s: got taken=%0b target=%h, expected taken=%0b target=%h",
               name, pred_taken, pred_target, et, etg);
    end
  endtask

  task automatic idle_inputs();
    update = 1'b0; upd_pc_clear(); stall = 1'b0; inval = 1'b0;
  endtask

  task automatic upd_pc_clear();
    update_pc = '0; act_taken = 1'b0; act_target = '0;
  endtask

  initial begin
    // Each lookup result reflects state before that vector's edge.
    vecs.push_back(mk(0, 0,  0, 0,  0, 0, PA, 0, 0));    // 0 empty
    vecs.push_back(mk(1, PA, 1, TA, 0, 0, PA, 0, 0));    // 1 allocate, ctr=2
    vecs.push_back(mk(0, 0,  0, 0,  0, 0, PA, 1, TA));   // 2 forwarded
    vecs.push_back(mk(0, 0,  0, 0,  0, 0, PA, 1, TA));   // 3 from array
    vecs.push_back(mk(1, PA, 1, TA, 0, 0, PA, 1, TA));   // 4 ctr 2->3
    vecs.push_back(mk(1, PA, 1, TA, 0, 0, PA, 1, TA));   // 5 ctr 3->3
    vecs.push_back(mk(1, PA, 0, 0,  0, 0, PA, 1, TA));   // 6 ctr 3->2
    vecs.push_back(mk(1, PA, 0, 0,  0, 0, PA, 1, TA));   // 7 ctr 2->1
    vecs.push_back(mk(1, PA, 0, 0,  0, 0, PA, 0, TA));   // 8 ctr 1->0
    vecs.push_back(mk(1, PA, 0, 0,  0, 0, PA, 0, TA));   // 9 ctr 0->0
    vecs.push_back(mk(1, PA, 1, TA, 0, 0, PA, 0, TA));   // 10 ctr 0->1
    vecs.push_back(mk(0, 0,  0, 0,  0, 0, PA, 0, TA));   // 11 ctr=1, no wrap
    vecs.push_back(mk(1, PA, 1, TA, 0, 0, PA, 0, TA));   // 12 ctr 1->2
    vecs.push_back(mk(0, 0,  0, 0,  0, 0, PA, 1, TA));   // 13 ctr=2
    vecs.push_back(mk(1, PA, 1, TA, 0, 0, PA, 1, TA));   // 14 ctr 2->3
    vecs.push_back(mk(1, PA, 0, 0,  0, 0, PA, 1, TA));   // 15 back-to-back 3->2
    vecs.push_back(mk(1, PA, 0, 0,  0, 0, PA, 1, TA));   // 16 sees 2, ->1
    vecs.push_back(mk(0, 0,  0, 0,  0, 0, PA, 0, TA));   // 17 ctr=1
    vecs.push_back(mk(1, PA, 1, TA, 0, 0, PA, 0, TA));   // 18 ctr 1->2
    vecs.push_back(mk(1, PA, 1, TA, 0, 0, PA, 1, TA));   // 19 ctr 2->3
    vecs.push_back(mk(1, PA, 0, 0,  1, 0, PA, 1, TA));   // 20 stalled, ignored
    vecs.push_back(mk(1, PA, 0, 0,  0, 0, PA, 1, TA));   // 21 ctr 3->2
    vecs.push_back(mk(1, PA, 0, 0,  0, 0, PA, 1, TA));   // 22 sees 2, ->1
    vecs.push_back(mk(0, 0,  0, 0,  0, 0, PA, 0, TA));   // 23 ctr=1
    vecs.push_back(mk(0, 0,  0, 0,  0, 0, PB, 0, 0));    // 24 alias miss
    vecs.push_back(mk(1, PB, 1, TB, 0, 0, PB, 0, 0));    // 25 alias replaces
    vecs.push_back(mk(0, 0,  0, 0,  0, 0, PB, 1, TB));   // 26
    vecs.push_back(mk(0, 0,  0, 0,  0, 0, PA, 0, 0));    // 27 old entry gone
    vecs.push_back(mk(1, PC, 0, 0,  0, 0, PC, 0, 0));    // 28 NT miss, no alloc
    vecs.push_back(mk(0, 0,  0, 0,  0, 0, PC, 0, 0));    // 29
    vecs.push_back(mk(1, PA, 1, TA, 0, 1, PB, 1, TB));   // 30 inval beats update
    vecs.push_back(mk(0, 0,  0, 0,  0, 0, PB, 0, 0));    // 31
    vecs.push_back(mk(0, 0,  0, 0,  0, 0, PA, 0, 0));    // 32 no allocation
    vecs.push_back(mk(1, PA, 1, TA, 0, 0, PA, 0, 0));    // 33 allocate
    vecs.push_back(mk(0, 0,  0, 0,  0, 1, PA, 1, TA));   // 34 inval with pending
    vecs.push_back(mk(0, 0,  0, 0,  0, 0, PA, 0, 0));    // 35 pending dropped

    rst = 1'b0;
    idle_inputs();
    pc = PA;
    #3;
    check("reset_hold", 1'b0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      update = vecs[i].upd; update_pc = vecs[i].upc; act_taken = vecs[i].at;
      act_target = vecs[i].atg; stall = vecs[i].stl; inval = vecs[i].inv;
      pc = vecs[i].lpc;
      #3;
      check($sformatf("vec%0d", i), vecs[i].exp_taken, vecs[i].exp_target);
      @(posedge clk); #1;
    end

    // Reset asserted while an update sits in the write buffer.
    update = 1'b1; update_pc = PB; act_taken = 1'b1; act_target = TB; pc = PB;
    @(posedge clk); #1;
    idle_inputs();
    #1;
    check("pend_before_rst", 1'b1, TB);
    rst = 1'b0;
    #1;
    check("rst_mid_drain", 1'b0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("after_rst_b", 1'b0, 32'h0);
    @(posedge clk); #1;
    check("after_rst_b2", 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
